// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch unit: default geometry,
// reset fetch address and the exported fetch-mode encoding.
package fetch_queue_pkg;

   localparam int unsigned DEF_XLEN     = 32'd16;
   localparam int unsigned DEF_DEPTH    = 32'd4;
   localparam int unsigned DEF_INC      = 32'd2;
   localparam logic [15:0] DEF_RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } fetch_mode_e;

   // Bits needed to hold a count of 0..n inclusive.
   function automatic int unsigned count_width(input int unsigned n);
      return $clog2(n) + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the
// decode-side valid/ready handshake and execute-side redirect/halt controls.
interface fetch_queue_if #(
   parameter int unsigned XLEN = fetch_queue_pkg::DEF_XLEN
);
   logic                          imem_req;
   logic [XLEN-1:0]               imem_addr;
   logic                          imem_gnt;
   logic                          imem_ack;
   logic [XLEN-1:0]               imem_data;
   logic                          out_valid;
   logic [XLEN-1:0]               out_instr;
   logic [XLEN-1:0]               out_pc;
   logic [XLEN-1:0]               out_pc_inc;
   logic                          out_ready;
   logic                          redirect;
   logic [XLEN-1:0]               redirect_pc;
   logic                          halt;
   fetch_queue_pkg::fetch_mode_e  mode;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_inc, mode,
      input  imem_gnt, imem_ack, imem_data, out_ready, redirect, redirect_pc, halt
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_inc, mode,
      output imem_gnt, imem_ack, imem_data, out_ready, redirect, redirect_pc, halt
   );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Single-clock FIFO with push/pop/flush and occupancy count; DEPTH must be a
// power of two. Flush clears pointers synchronously and wins over push/pop.
module sync_fifo
   import fetch_queue_pkg::*;
#(
   parameter int unsigned WIDTH = 32'd8,
   parameter int unsigned DEPTH = 32'd4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = count_width(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             full_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_s    = (count_r == CW'(DEPTH));
   assign pop_ok_s  = pop && (count_r != '0);
   assign push_ok_s = push && (!full_s || pop_ok_s);
   assign rdata     = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
      end
   end

   // Storage array; cleared on reset so the head never shows stale X data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_ok_s && !flush) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction prefetch: in-order requests to a variable-latency
// memory, DEPTH-entry instruction queue, redirect flush with response discard.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned    XLEN     = DEF_XLEN,
   parameter int unsigned    DEPTH    = DEF_DEPTH,
   parameter int unsigned    INC      = DEF_INC,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
   input  logic          clk,
   input  logic          rst,
   fetch_queue_if.master bus
);
   // Discarded requests keep their shadow slots while new ones are issued,
   // so the PC shadow is twice the queue depth.
   localparam int unsigned SDEPTH = 32'd2 * DEPTH;
   localparam int unsigned CW     = count_width(DEPTH);
   localparam int unsigned SCW    = count_width(SDEPTH);

   logic [XLEN-1:0]   fetch_pc_r;
   logic [XLEN-1:0]   fetch_pc_n;
   logic [CW-1:0]     outstanding_r;
   logic [CW-1:0]     outstanding_n;
   logic [SCW-1:0]    discard_r;
   logic [SCW-1:0]    discard_n;
   fetch_mode_e       mode_r;
   fetch_mode_e       mode_n;

   logic [CW-1:0]     q_count_s;
   logic [2*XLEN-1:0] q_rdata_s;
   logic [SCW-1:0]    sh_count_s;
   logic [XLEN-1:0]   sh_rdata_s;
   logic              q_valid_s;
   logic              credit_ok_s;
   logic              sh_room_s;
   logic              imem_req_s;
   logic              fire_s;
   logic              ack_ok_s;
   logic              enq_s;
   logic              deq_s;

   assign q_valid_s   = (q_count_s != '0);
   assign credit_ok_s = (({1'b0, q_count_s} + {1'b0, outstanding_r}) < (CW+1)'(DEPTH));
   assign sh_room_s   = (sh_count_s < SCW'(SDEPTH));
   assign imem_req_s  = rst && !bus.redirect && !bus.halt && credit_ok_s && sh_room_s;
   assign fire_s      = imem_req_s && bus.imem_gnt;
   // An ack with nothing pending is a protocol error and is dropped here.
   assign ack_ok_s    = bus.imem_ack && ((outstanding_r != '0) || (discard_r != '0));
   assign enq_s       = ack_ok_s && (discard_r == '0) && !bus.redirect;
   assign deq_s       = q_valid_s && bus.out_ready;

   sync_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_instr_q (
      .clk   (clk),
      .rst_n (rst),
      .push  (enq_s),
      .pop   (deq_s),
      .flush (bus.redirect),
      .wdata ({bus.imem_data, sh_rdata_s}),
      .rdata (q_rdata_s),
      .count (q_count_s)
   );

   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (SDEPTH)
   ) u_pc_shadow (
      .clk   (clk),
      .rst_n (rst),
      .push  (fire_s),
      .pop   (ack_ok_s),
      .flush (1'b0),
      .wdata (fetch_pc_r),
      .rdata (sh_rdata_s),
      .count (sh_count_s)
   );

   // Next fetch PC and in-flight accounting; redirect overrides everything.
   always_comb begin
      fetch_pc_n    = fetch_pc_r;
      outstanding_n = outstanding_r;
      discard_n     = discard_r;
      if (bus.redirect) begin
         fetch_pc_n    = bus.redirect_pc;
         outstanding_n = '0;
         discard_n     = discard_r + SCW'(outstanding_r) - SCW'(ack_ok_s);
      end else begin
         if (fire_s) begin
            fetch_pc_n = fetch_pc_r + XLEN'(INC);
         end else begin
            fetch_pc_n = fetch_pc_r;
         end
         outstanding_n = outstanding_r + CW'(fire_s) - CW'(enq_s);
         if (ack_ok_s && (discard_r != '0)) begin
            discard_n = discard_r - SCW'(1'b1);
         end else begin
            discard_n = discard_r;
         end
      end
   end

   // Debug mode derived from the upcoming state so it lines up with it.
   always_comb begin
      if (bus.halt && (outstanding_n == '0)) begin
         mode_n = HALT;
      end else if (discard_n != '0) begin
         mode_n = FLUSH;
      end else begin
         mode_n = RUN;
      end
   end

   // Fetch engine state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_r    <= RESET_PC;
         outstanding_r <= '0;
         discard_r     <= '0;
         mode_r        <= RUN;
      end else begin
         fetch_pc_r    <= fetch_pc_n;
         outstanding_r <= outstanding_n;
         discard_r     <= discard_n;
         mode_r        <= mode_n;
      end
   end

   assign bus.imem_req   = imem_req_s;
   assign bus.imem_addr  = fetch_pc_r;
   assign bus.out_valid  = q_valid_s;
   assign bus.out_instr  = q_valid_s ? q_rdata_s[2*XLEN-1:XLEN] : '0;
   assign bus.out_pc     = q_valid_s ? q_rdata_s[XLEN-1:0] : '0;
   assign bus.out_pc_inc = q_valid_s ? (q_rdata_s[XLEN-1:0] + XLEN'(INC)) : '0;
   assign bus.mode       = mode_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: latency-programmable memory model and a
// scoreboard of expected {pc, instr} filled on every issued fetch.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int unsigned XLEN   = 16;
   localparam logic [15:0] RST_PC = 16'h0000;

   typedef struct { logic [15:0] addr; int rem; } mem_t;
   typedef struct { logic [15:0] pc; logic [15:0] instr; } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_queue_if #(.XLEN(XLEN)) bus ();

   fetch_queue #(
      .XLEN(XLEN), .DEPTH(4), .INC(2), .RESET_PC(RST_PC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   mem_t        pend[$];
   exp_t        sb[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          n_fire = 0;
   int          n_deq  = 0;
   int          lat    = 1;
   logic [15:0] exp_fetch_pc = RST_PC;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // In-order memory: each accepted request is answered lat cycles later.
   always @(negedge clk) begin
      if (!rst) begin
         pend.delete();
         bus.imem_ack  = 1'b0;
         bus.imem_data = 16'h0000;
      end else begin
         if (bus.imem_ack && pend.size() > 0) void'(pend.pop_front());
         foreach (pend[i]) if (pend[i].rem > 0) pend[i].rem = pend[i].rem - 1;
         if (pend.size() > 0 && pend[0].rem == 0) begin
            bus.imem_ack  = 1'b1;
            bus.imem_data = mem_word(pend[0].addr);
         end else begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = 16'h0000;
         end
         if (bus.imem_req && bus.imem_gnt) pend.push_back('{addr: bus.imem_addr, rem: lat});
      end
   end

   // Scoreboard: fires push the expected stream, deliveries pop and compare.
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] inc_exp;
      if (!rst) begin
         sb.delete();
         exp_fetch_pc = RST_PC;
      end else if (bus.redirect) begin
         n_cmp++;
         if (bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_req_low: imem_req=%b required 0", bus.imem_req);
         end
         sb.delete();
         exp_fetch_pc = bus.redirect_pc;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_deq++;
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: out_pc=%h delivered, nothing expected", bus.out_pc);
            end else begin
               e = sb.pop_front();
               inc_exp = e.pc + 16'd2;
               if (bus.out_pc !== e.pc || bus.out_instr !== e.instr || bus.out_pc_inc !== inc_exp) begin
                  n_fail++;
                  $display("FAIL sb_output: got pc=%h instr=%h inc=%h required pc=%h instr=%h inc=%h",
                           bus.out_pc, bus.out_instr, bus.out_pc_inc, e.pc, e.instr, inc_exp);
               end
            end
         end
         if (bus.imem_req && bus.imem_gnt) begin
            n_fire++;
            n_cmp++;
            if (bus.imem_addr !== exp_fetch_pc) begin
               n_fail++;
               $display("FAIL fetch_addr: imem_addr=%h required %h", bus.imem_addr, exp_fetch_pc);
            end
            sb.push_back('{pc: exp_fetch_pc, instr: mem_word(exp_fetch_pc)});
            exp_fetch_pc = exp_fetch_pc + 16'd2;
         end
      end
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL reset_ctrl: valid=%b req=%b addr=%h required 0 0 %h",
                  bus.out_valid, bus.imem_req, bus.imem_addr, RST_PC);
      end
      n_cmp++;
      if (bus.out_instr !== 16'h0 || bus.out_pc !== 16'h0 || bus.out_pc_inc !== 16'h0 || bus.mode !== RUN) begin
         n_fail++;
         $display("FAIL reset_data: instr=%h pc=%h inc=%h mode=%0d required 0 0 0 0",
                  bus.out_instr, bus.out_pc, bus.out_pc_inc, bus.mode);
      end
      @(posedge clk); #1 rst = 1'b1; #1;
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL first_req: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.out_valid !== (i >= 2)) begin
            n_fail++;
            $display("FAIL stream_valid[%0d]: out_valid=%b required %b", i, bus.out_valid, (i >= 2));
         end
      end
   endtask

   task automatic test_full();
      int f0;
      int d0;
      @(posedge clk); #1;
      bus.out_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
      @(posedge clk); #1;
      bus.redirect = 1'b0; f0 = n_fire;
      repeat (12) @(posedge clk);
      #1;
      n_cmp++;
      if (n_fire - f0 !== 4) begin
         n_fail++;
         $display("FAIL full_fires: fires=%0d required 4", n_fire - f0);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0040) begin
         n_fail++;
         $display("FAIL full_hold: req=%b valid=%b pc=%h required 0 1 0040", bus.imem_req, bus.out_valid, bus.out_pc);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1; d0 = n_deq; f0 = n_fire;
      repeat (6) @(posedge clk);
      #1;
      n_cmp++;
      if (n_deq - d0 < 4 || n_fire - f0 < 1) begin
         n_fail++;
         $display("FAIL full_release: delivered=%0d fires=%0d required >=4 >=1", n_deq - d0, n_fire - f0);
      end
   endtask

   task automatic test_redirect_latency();
      logic found;
      lat = 3;
      repeat (10) @(posedge clk);
      #1 bus.redirect = 1'b1; bus.redirect_pc = 16'h0100;
      @(posedge clk); #1 bus.redirect = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100 || bus.mode !== FLUSH) begin
         n_fail++;
         $display("FAIL redir_next: valid=%b req=%b addr=%h mode=%0d required 0 1 0100 %0d",
                  bus.out_valid, bus.imem_req, bus.imem_addr, bus.mode, FLUSH);
      end
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = bus.out_valid;
      end
      n_cmp++;
      if (!found || bus.out_pc !== 16'h0100) begin
         n_fail++;
         $display("FAIL redir_first: seen=%b out_pc=%h required 1 0100", found, bus.out_pc);
      end
   endtask

   task automatic test_redirect_collision();
      logic found;
      lat = 1;
      repeat (8) @(posedge clk);
      #1 bus.redirect = 1'b1; bus.redirect_pc = 16'h0200;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.imem_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_pre: valid=%b ack=%b required 1 1", bus.out_valid, bus.imem_ack);
      end
      @(posedge clk); #1 bus.redirect = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_flush: out_valid=%b required 0", bus.out_valid);
      end
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = bus.out_valid;
      end
      n_cmp++;
      if (!found || bus.out_pc !== 16'h0200) begin
         n_fail++;
         $display("FAIL collide_first: seen=%b out_pc=%h required 1 0200", found, bus.out_pc);
      end
   endtask

   task automatic test_halt();
      int f0;
      int d0;
      lat = 3;
      @(posedge clk); #1 bus.redirect = 1'b1; bus.redirect_pc = 16'h0300;
      @(posedge clk); #1 bus.redirect = 1'b0; f0 = n_fire; d0 = n_deq;
      repeat (2) @(posedge clk);
      #1 bus.halt = 1'b1;
      n_cmp++;
      if (n_fire - f0 !== 2) begin
         n_fail++;
         $display("FAIL halt_setup: fires=%0d required 2", n_fire - f0);
      end
      repeat (8) @(posedge clk);
      #1;
      n_cmp++;
      if (n_fire - f0 !== 2 || n_deq - d0 !== 2) begin
         n_fail++;
         $display("FAIL halt_drain: fires=%0d delivered=%0d required 2 2", n_fire - f0, n_deq - d0);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.mode !== HALT || bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0304) begin
         n_fail++;
         $display("FAIL halt_state: mode=%0d req=%b addr=%h required %0d 0 0304",
                  bus.mode, bus.imem_req, bus.imem_addr, HALT);
      end
      @(posedge clk); #1 bus.halt = 1'b0; #1;
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0304) begin
         n_fail++;
         $display("FAIL halt_resume: req=%b addr=%h required 1 0304", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      repeat (6) @(posedge clk);
      #1 rst = 1'b0; #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== RST_PC ||
          bus.out_pc !== 16'h0 || bus.out_instr !== 16'h0 || bus.out_pc_inc !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid: valid=%b req=%b addr=%h pc=%h instr=%h inc=%h required all zero",
                  bus.out_valid, bus.imem_req, bus.imem_addr, bus.out_pc, bus.out_instr, bus.out_pc_inc);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1; #1;
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL reset_restart: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, RST_PC);
      end
      repeat (6) @(posedge clk);
   endtask

   task automatic test_wrap();
      logic found;
      lat = 1;
      @(posedge clk); #1 bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFC;
      @(posedge clk); #1 bus.redirect = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = bus.out_valid && (bus.out_pc == 16'hFFFE);
      end
      n_cmp++;
      if (!found || bus.out_pc_inc !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_inc: seen=%b out_pc_inc=%h required 1 0000", found, bus.out_pc_inc);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_pc: valid=%b out_pc=%h required 1 0000", bus.out_valid, bus.out_pc);
      end
   endtask

   initial begin
      rst             = 1'b0;
      bus.imem_gnt    = 1'b1;
      bus.out_ready   = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'h0000;
      bus.halt        = 1'b0;
      test_reset();
      test_stream();
      test_full();
      test_redirect_latency();
      test_redirect_collision();
      test_halt();
      test_reset_mid();
      test_wrap();
      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
